// File: rtl/isp_ol_walker_if.sv
// Walker-side bus: region start, VRAM read port and primitive descriptor stream.
interface isp_ol_walker_if #(parameter int ADDR_W = 24);
    logic              start;
    logic [ADDR_W-1:0] list_addr;
    logic [ADDR_W-1:0] param_base;
    logic              vram_rd;
    logic [ADDR_W-1:0] vram_addr;
    logic [31:0]       vram_din;
    logic              prim_valid;
    logic              prim_ready;
    logic [ADDR_W-1:0] prim_addr;
    logic [1:0]        prim_type;
    logic [3:0]        prim_skip;
    logic [2:0]        prim_strip_idx;
    logic              busy;
    logic              done;
    logic              abort;

    modport master (
        input  start, list_addr, param_base, vram_din, prim_ready,
        output vram_rd, vram_addr, prim_valid, prim_addr, prim_type, prim_skip,
               prim_strip_idx, busy, done, abort
    );
    modport slave (
        output start, list_addr, param_base, vram_din, prim_ready,
        input  vram_rd, vram_addr, prim_valid, prim_addr, prim_type, prim_skip,
               prim_strip_idx, busy, done, abort
    );
endinterface

// File: rtl/isp_ol_walker.sv
// Object List walker: fetches tile list entries, follows links and emits one
// descriptor per strip triangle / array element to the ISP parameter parser.
module isp_ol_walker #(
    parameter int ADDR_W      = 24,
    parameter int MAX_ENTRIES = 4096
) (
    input logic            clock,
    input logic            reset,
    isp_ol_walker_if.master bus
);
    typedef enum logic [1:0] {IDLE, FETCH, DECODE, EMIT} state_t;
    localparam int CNT_W = $clog2(MAX_ENTRIES + 2);
    localparam logic [CNT_W-1:0] LIMIT = CNT_W'(MAX_ENTRIES);

    state_t            state;
    logic [ADDR_W-1:0] ptr;
    logic [ADDR_W-1:0] stride;
    logic [CNT_W-1:0]  n_entries;
    logic [5:0]        mask;
    logic [3:0]        remain;

    logic [31:0]       e;
    logic [5:0]        e_mask;
    logic [3:0]        e_skip;
    logic [ADDR_W-1:0] e_base;
    logic [ADDR_W-1:0] e_stride;
    logic [ADDR_W-1:0] e_link;
    logic [ADDR_W-1:0] ptr_next;
    logic [5:0]        next_mask;
    logic              last;

    // Lowest set bit index; bit 0 of the reordered mask is triangle 0.
    function automatic logic [2:0] first_set(input logic [5:0] m);
        first_set = '0;
        for (int i = 5; i >= 0; i--)
            if (m[i]) first_set = 3'(i);
    endfunction

    always_comb begin
        e        = bus.vram_din;
        e_mask   = '0;
        for (int i = 0; i < 6; i++) e_mask[i] = e[30-i];
        e_skip   = e[24:21];
        e_base   = bus.param_base + ADDR_W'({e[20:0], 2'b00});
        e_stride = e[29] ? ADDR_W'(60 + 16 * int'(e_skip))
                         : ADDR_W'(48 + 12 * int'(e_skip));
        e_link   = ADDR_W'({e[23:2], 2'b00});
        ptr_next = ptr + ADDR_W'(4);
        next_mask = mask & ~(6'b1 << bus.prim_strip_idx);
        last     = (bus.prim_type == 2'd0) ? (next_mask == '0) : (remain == '0);
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state              <= IDLE;
            ptr                <= '0;
            stride             <= '0;
            n_entries          <= '0;
            mask               <= '0;
            remain             <= '0;
            bus.vram_rd        <= 1'b0;
            bus.vram_addr      <= '0;
            bus.prim_valid     <= 1'b0;
            bus.prim_addr      <= '0;
            bus.prim_type      <= '0;
            bus.prim_skip      <= '0;
            bus.prim_strip_idx <= '0;
            bus.busy           <= 1'b0;
            bus.done           <= 1'b0;
            bus.abort          <= 1'b0;
        end else begin
            bus.done    <= 1'b0;
            bus.abort   <= 1'b0;
            bus.vram_rd <= 1'b0;
            case (state)
                IDLE: begin
                    bus.busy <= 1'b0;
                    // done still high means busy is still visible this cycle
                    if (bus.start && !bus.done) begin
                        ptr           <= bus.list_addr & ~ADDR_W'(3);
                        bus.vram_addr <= bus.list_addr & ~ADDR_W'(3);
                        bus.vram_rd   <= 1'b1;
                        n_entries     <= '0;
                        bus.busy      <= 1'b1;
                        state         <= FETCH;
                    end
                end
                FETCH: state <= DECODE;
                DECODE: begin
                    n_entries <= n_entries + 1'b1;
                    if (n_entries >= LIMIT) begin
                        bus.done  <= 1'b1;
                        bus.abort <= 1'b1;
                        state     <= IDLE;
                    end else if (e[31:29] == 3'b111) begin
                        if (e[28]) begin
                            bus.done <= 1'b1;
                            state    <= IDLE;
                        end else begin
                            ptr           <= e_link;
                            bus.vram_addr <= e_link;
                            bus.vram_rd   <= 1'b1;
                            state         <= FETCH;
                        end
                    end else if (e[31:29] == 3'b110 || (!e[31] && e_mask == '0)) begin
                        ptr           <= ptr_next;
                        bus.vram_addr <= ptr_next;
                        bus.vram_rd   <= 1'b1;
                        state         <= FETCH;
                    end else begin
                        bus.prim_valid <= 1'b1;
                        bus.prim_addr  <= e_base;
                        bus.prim_skip  <= e_skip;
                        mask           <= e_mask;
                        remain         <= e[28:25];
                        stride         <= e_stride;
                        if (!e[31]) begin
                            bus.prim_type      <= 2'd0;
                            bus.prim_strip_idx <= first_set(e_mask);
                        end else begin
                            bus.prim_type      <= e[29] ? 2'd2 : 2'd1;
                            bus.prim_strip_idx <= '0;
                        end
                        state <= EMIT;
                    end
                end
                EMIT: begin
                    if (bus.prim_ready) begin
                        if (last) begin
                            bus.prim_valid <= 1'b0;
                            ptr            <= ptr_next;
                            bus.vram_addr  <= ptr_next;
                            bus.vram_rd    <= 1'b1;
                            state          <= FETCH;
                        end else if (bus.prim_type == 2'd0) begin
                            mask               <= next_mask;
                            bus.prim_strip_idx <= first_set(next_mask);
                        end else begin
                            remain        <= remain - 4'd1;
                            bus.prim_addr <= bus.prim_addr + stride;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_isp_ol_walker.sv
// Scoreboard bench for isp_ol_walker: VRAM model, ready patterns, protocol monitor.
module tb_isp_ol_walker;
    typedef struct packed {
        logic [23:0] addr;
        logic [1:0]  typ;
        logic [3:0]  skip;
        logic [2:0]  idx;
    } desc_t;

    logic clock = 1'b0;
    logic reset = 1'b1;
    always #5 clock = ~clock;

    isp_ol_walker_if #(.ADDR_W(24)) bus();
    isp_ol_walker #(.ADDR_W(24), .MAX_ENTRIES(4)) dut (.clock(clock), .reset(reset), .bus(bus));

    logic [31:0] mem [int];
    desc_t       sb[$];
    logic [23:0] rd_log[$];
    int n_chk = 0, n_fail = 0;
    int n_done = 0, n_abort = 0, viol = 0, rmode = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // VRAM: one-cycle read latency; unknown addresses read as end-of-list.
    initial begin
        bus.vram_din = '0;
        forever begin
            @(posedge clock);
            if (bus.vram_rd)
                bus.vram_din <= mem.exists(int'(bus.vram_addr)) ? mem[int'(bus.vram_addr)] : 32'hF000_0000;
        end
    end

    initial begin
        bus.prim_ready = 1'b1;
        forever begin
            @(posedge clock); #1;
            case (rmode)
                0: bus.prim_ready = 1'b1;
                1: bus.prim_ready = !bus.prim_ready;
                default: bus.prim_ready = 1'b0;
            endcase
        end
    end

    // Monitor: scoreboard pops on handshake, protocol violations are tallied.
    initial begin
        desc_t cur, held, exp;
        logic stall_prev;
        stall_prev = 1'b0;
        held = '0;
        forever begin
            @(negedge clock);
            cur = {bus.prim_addr, bus.prim_type, bus.prim_skip, bus.prim_strip_idx};
            if (bus.vram_rd) rd_log.push_back(bus.vram_addr);
            if (bus.done) n_done++;
            if (bus.abort) n_abort++;
            if (bus.done && bus.prim_valid) viol++;
            if (bus.abort && !bus.done) viol++;
            if (bus.vram_rd && bus.prim_valid) viol++;
            if (stall_prev && (!bus.prim_valid || cur != held)) viol++;
            stall_prev = bus.prim_valid && !bus.prim_ready && !reset;
            held = cur;
            if (bus.prim_valid && bus.prim_ready) begin
                exp = (sb.size() > 0) ? sb.pop_front() : '1;
                chk("desc", cur, exp);
            end
        end
    end

    task automatic push(input logic [23:0] a, input logic [1:0] t, input logic [3:0] s, input logic [2:0] i);
        desc_t d;
        d = {a, t, s, i};
        sb.push_back(d);
    endtask

    task automatic run_walk(input string tag, input logic [23:0] la, input logic [23:0] pb,
                            input logic exp_abort, input int exp_rds, input bit mid_start);
        int k;
        logic exp_v3;
        n_done = 0; n_abort = 0; viol = 0;
        rd_log.delete();
        exp_v3 = (sb.size() > 0);
        bus.list_addr = la; bus.param_base = pb; bus.start = 1'b1;
        @(posedge clock); #1;
        bus.start = 1'b0;
        chk({tag, "_rd1"}, bus.vram_rd, 1);
        chk({tag, "_addr1"}, bus.vram_addr, la);
        chk({tag, "_busy1"}, bus.busy, 1);
        @(posedge clock); #1;
        if (mid_start) begin
            bus.start = 1'b1;
            bus.list_addr = 24'h007000;
        end
        @(posedge clock); #1;
        bus.start = 1'b0;
        chk({tag, "_valid3"}, bus.prim_valid, exp_v3);
        k = 0;
        while (!bus.done && k < 300) begin
            @(posedge clock); #1;
            k++;
        end
        chk({tag, "_timeout"}, k < 300, 1);
        chk({tag, "_abort"}, bus.abort, exp_abort);
        chk({tag, "_busy_done"}, bus.busy, 1);
        @(posedge clock); #1;
        chk({tag, "_busy_after"}, bus.busy, 0);
        @(posedge clock); #1;
        chk({tag, "_sb_left"}, sb.size(), 0);
        chk({tag, "_ndone"}, n_done, 1);
        chk({tag, "_nabort"}, n_abort, exp_abort);
        chk({tag, "_viol"}, viol, 0);
        chk({tag, "_nrd"}, rd_log.size(), exp_rds);
        sb.delete();
    endtask

    initial begin
        logic [31:0] e;
        logic [23:0] base;
        int k;
        bus.start = 1'b0; bus.list_addr = '0; bus.param_base = '0;
        repeat (3) @(posedge clock);
        #1;
        chk("rst_valid", bus.prim_valid, 0);
        chk("rst_busy", bus.busy, 0);
        chk("rst_done", bus.done, 0);
        chk("rst_rd", bus.vram_rd, 0);
        reset = 1'b0;
        @(posedge clock); #1;

        // full strip
        mem.delete();
        mem[32'h1000] = 32'h7E00_0010; mem[32'h1004] = 32'hF000_0000;
        for (int i = 0; i < 6; i++) push(24'h100040, 2'd0, 4'd0, 3'(i));
        run_walk("t1", 24'h001000, 24'h100000, 0, 2, 0);

        // triangle array, count 4, skip 1
        mem.delete();
        mem[32'h1000] = 32'h8620_0020; mem[32'h1004] = 32'hF000_0000;
        for (int i = 0; i < 4; i++) push(24'h80 + 24'(i * (3 + 3 * (3 + 1)) * 4), 2'd1, 4'd1, 3'd0);
        run_walk("t2", 24'h001000, 24'h000000, 0, 2, 0);

        // quad then non-terminating link
        mem.delete();
        mem[32'h1000] = 32'hA000_0004; mem[32'h1004] = 32'hE000_2000; mem[32'h2000] = 32'hF000_0000;
        push(24'h100010, 2'd2, 4'd0, 3'd0);
        run_walk("t3", 24'h001000, 24'h100000, 0, 3, 0);
        chk("t3_rd0", rd_log[0], 24'h001000);
        chk("t3_rd1", rd_log[1], 24'h001004);
        chk("t3_rd2", rd_log[2], 24'h002000);

        // quad array with skip 2 whose addresses wrap past 2^24
        mem.delete();
        e = 32'hA000_0000 | (32'd1 << 25) | (32'd2 << 21) | 32'h001F_FFFF;
        mem[32'h3000] = e; mem[32'h3004] = 32'hF000_0000;
        base = 24'hA00000 + 24'(32'h1F_FFFF * 4);
        for (int i = 0; i < 2; i++) push(base + 24'(i * (3 + 4 * (3 + 2)) * 4), 2'd2, 4'd2, 3'd0);
        run_walk("t3w", 24'h003000, 24'hA00000, 0, 2, 0);

        // sparse strip under toggling ready
        rmode = 1;
        mem.delete();
        mem[32'h1000] = 32'h4260_0001; mem[32'h1004] = 32'hF000_0000;
        push(24'h000104, 2'd0, 4'd3, 3'd0);
        push(24'h000104, 2'd0, 4'd3, 3'd5);
        run_walk("t4", 24'h001000, 24'h000100, 0, 2, 0);
        rmode = 0;

        // reserved, empty strip, end; start pulsed mid-walk
        mem.delete();
        mem[32'h1000] = 32'hC000_0000; mem[32'h1004] = 32'h0000_0000; mem[32'h1008] = 32'hF000_0000;
        mem[32'h7000] = 32'h7E00_0000;
        run_walk("t5", 24'h001000, 24'h000000, 0, 3, 1);
        chk("t5_rd2", rd_log[2], 24'h001008);

        // exactly MAX_ENTRIES entries: no abort
        mem.delete();
        mem[32'h1000] = 32'hC000_0000; mem[32'h1004] = 32'hC000_0000;
        mem[32'h1008] = 32'hC000_0000; mem[32'h100C] = 32'hF000_0000;
        run_walk("t6a", 24'h001000, 24'h000000, 0, 4, 0);

        // self-looping link trips the watchdog on the 5th decode
        mem.delete();
        mem[32'h1000] = 32'hE000_1000;
        run_walk("t6b", 24'h001000, 24'h000000, 1, 5, 0);

        // reset during EMIT
        rmode = 2;
        mem.delete();
        mem[32'h1000] = 32'h7E00_0010;
        n_done = 0;
        bus.list_addr = 24'h001000; bus.param_base = 24'h0; bus.start = 1'b1;
        @(posedge clock); #1;
        bus.start = 1'b0;
        k = 0;
        while (!bus.prim_valid && k < 10) begin
            @(posedge clock); #1;
            k++;
        end
        chk("t7_emit_reached", bus.prim_valid, 1);
        reset = 1'b1;
        @(posedge clock); #1;
        reset = 1'b0;
        chk("t7_valid", bus.prim_valid, 0);
        chk("t7_busy", bus.busy, 0);
        repeat (5) @(posedge clock);
        #1;
        chk("t7_nodone", n_done, 0);
        rmode = 0;

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
